// File: rtl/mau_arbiter.sv
// mau_arbiter: two-port (fetch, load/store) arbiter onto a single memory port.
// One transaction at a time, registered memory request, per-transaction
// timeout, and flush handling for in-flight fetches.
// Optional round-robin tie-break is enabled by defining MAU_ARB_RR_EN;
// otherwise load/store always wins a tie.
module mau_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_DRAIN} state_t;

  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_wait;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic        r_if_ack, r_ls_ack, r_mem_err;
  logic [31:0] r_if_rdata, r_ls_rdata;

  logic w_if_ok, w_ls_ok, w_grant_ls, w_grant_if;
  logic w_timeout, w_start;
  logic w_done_if, w_done_ls, w_err;

  // A port whose ack is pulsing still holds its req this cycle; don't regrant it.
  assign w_ls_ok = ls_req && !r_ls_ack;
  assign w_if_ok = if_req && !flush && !r_if_ack;

`ifdef MAU_ARB_RR_EN
  logic r_last_ls;
  assign w_grant_ls = w_ls_ok && (!w_if_ok || !r_last_ls);
`else
  assign w_grant_ls = w_ls_ok;
`endif
  assign w_grant_if = w_if_ok && !w_grant_ls;

  assign w_timeout = !mem_ack && (r_wait == TO_M1);
  assign w_start   = (r_state == S_IDLE) && (w_next != S_IDLE);

  // Next-state and completion decode
  always_comb begin
    w_next    = r_state;
    w_done_if = 1'b0;
    w_done_ls = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_ls)      w_next = S_DATA;
        else if (w_grant_if) w_next = S_FETCH;
      end
      S_FETCH: begin
        // flush with a same-cycle ack discards the data
        if (mem_ack) begin
          w_next    = S_IDLE;
          w_done_if = !flush;
        end else if (flush) begin
          w_next = S_DRAIN;
        end else if (w_timeout) begin
          w_next    = S_IDLE;
          w_done_if = 1'b1;
          w_err     = 1'b1;
        end
      end
      S_DATA: begin
        if (mem_ack) begin
          w_next    = S_IDLE;
          w_done_ls = 1'b1;
        end else if (w_timeout) begin
          w_next    = S_IDLE;
          w_done_ls = 1'b1;
          w_err     = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_next = S_IDLE;
          w_err  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Memory request register: loaded on grant, held until ack/timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      r_mem_req <= 1'b1;
      if (w_grant_ls) begin
        r_mem_addr  <= ls_addr;
        r_mem_we    <= ls_we;
        r_mem_wdata <= ls_wdata;
      end else begin
        r_mem_addr  <= if_addr;
        r_mem_we    <= 1'b0;
        r_mem_wdata <= '0;
      end
    end else if (w_next == S_IDLE) begin
      r_mem_req <= 1'b0;
    end
  end

  // Wait counter: cleared on entering a busy state, counts ack-low cycles
  always_ff @(posedge clk) begin
    if (reset)                                       r_wait <= '0;
    else if (w_start)                                r_wait <= '0;
    else if (r_state == S_FETCH && w_next == S_DRAIN) r_wait <= '0;
    else if (r_state != S_IDLE && !mem_ack)          r_wait <= r_wait + 8'd1;
  end

  // Ack pulses, error pulse and captured read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_mem_err  <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_if_ack  <= w_done_if;
      r_ls_ack  <= w_done_ls;
      r_mem_err <= w_err;
      if (w_done_if)              r_if_rdata <= w_err ? 32'h0 : mem_rdata;
      if (w_done_ls && !r_mem_we) r_ls_rdata <= w_err ? 32'h0 : mem_rdata;
    end
  end

`ifdef MAU_ARB_RR_EN
  // Last-grant tracker for the round-robin tie-break (reset favours data next)
  always_ff @(posedge clk) begin
    if (reset)        r_last_ls <= 1'b0;
    else if (w_start) r_last_ls <= w_grant_ls;
  end
`endif

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ack    = r_if_ack;
  assign ls_ack    = r_ls_ack;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;
  assign mem_err   = r_mem_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mau_arbiter.sv
// Directed bench for mau_arbiter with an ack scoreboard.
module tb_mau_arbiter;

  localparam int TO = 4;
`ifdef MAU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, reset;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ack;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        flush;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, mem_err;

  mau_arbiter #(.TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          errs = 0;
  int          checks = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_ls = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Scoreboard: every ack pulse pops the oldest expected completion
  always @(negedge clk) begin
    if (if_ack || ls_ack) begin
      exp_t e;
      chk1("ack_both", if_ack & ls_ack, 1'b0);
      chk("ack_expected", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk1("ack_port", ls_ack, e.is_ls);
        chk("ack_rdata", e.is_ls ? ls_rdata : if_rdata, e.rdata);
      end
    end
  end

  // One complete transaction with ack after lat cycles (lat <= 3)
  task automatic xact(input bit ls, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
    exp_t e;
    if (ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
      if (!we) exp_ls = rdata;
      e.rdata = exp_ls;
    end else begin
      if_req = 1'b1; if_addr = addr;
      exp_if = rdata;
      e.rdata = rdata;
    end
    e.is_ls = ls;
    sbq.push_back(e);
    cyc();
    chk1("grant_req", mem_req, 1'b1);
    chk("grant_addr", mem_addr, addr);
    chk1("grant_we", mem_we, ls & we);
    chk("grant_wdata", mem_wdata, ls ? wdata : 32'h0);
    chk1("grant_busy", busy, 1'b1);
    repeat (lat - 1) cyc();
    chk1("hold_req", mem_req, 1'b1);
    chk("hold_addr", mem_addr, addr);
    mem_ack = 1'b1; mem_rdata = rdata;
    cyc();
    mem_ack = 1'b0; mem_rdata = $urandom;
    chk1("ack_pulse", ls ? ls_ack : if_ack, 1'b1);
    chk1("ack_drop_req", mem_req, 1'b0);
    if_req = 1'b0; ls_req = 1'b0;
    cyc();
    chk1("ack_single", ls ? ls_ack : if_ack, 1'b0);
    chk1("ack_idle", busy, 1'b0);
  endtask

  // Both ports request together; check which one was granted
  task automatic tie(input bit win_ls, input int n);
    exp_t e;
    if_req = 1'b1; if_addr = 32'h300 + n;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400 + n; ls_wdata = '0;
    e.is_ls = win_ls;
    e.rdata = 32'h7700_0000 + n;
    if (win_ls) exp_ls = e.rdata; else exp_if = e.rdata;
    sbq.push_back(e);
    cyc();
    chk("tie_grant", mem_addr, win_ls ? 32'h400 + n : 32'h300 + n);
    mem_ack = 1'b1; mem_rdata = e.rdata;
    cyc();
    mem_ack = 1'b0;
    chk1("tie_ack", win_ls ? ls_ack : if_ack, 1'b1);
    if_req = 1'b0; ls_req = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) cyc();
    // reset state
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_ls_ack", ls_ack, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_err", mem_err, 1'b0);
    reset = 1'b0;
    cyc();

    // fetch, ack 3 cycles after mem_req
    xact(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    // load then store; the store leaves ls_rdata alone
    xact(1'b1, 1'b0, 32'h210, 32'h0, 32'hA5A55A5A, 1);
    xact(1'b1, 1'b1, 32'h200, 32'h12345678, 32'hCAFE0000, 2);
    chk("store_keeps_rdata", ls_rdata, 32'hA5A55A5A);

    // last grant = fetch before the tie rounds
    xact(1'b0, 1'b0, 32'h110, 32'h0, 32'h0BADF00D, 1);
    for (int n = 0; n < 4; n++) tie(RR ? (n % 2 == 0) : 1'b1, n);

    // flush in IDLE blocks the fetch grant that cycle
    if_req = 1'b1; if_addr = 32'h520; flush = 1'b1;
    cyc();
    chk1("idle_flush_noreq", mem_req, 1'b0);
    chk1("idle_flush_nobusy", busy, 1'b0);
    flush = 1'b0;
    xact(1'b0, 1'b0, 32'h520, 32'h0, 32'h55550520, 1);

    // flush one cycle into FETCH -> DRAIN, ack 2 cycles later, no if_ack
    if_req = 1'b1; if_addr = 32'h500;
    cyc();
    chk1("drain_grant", mem_req, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0; if_req = 1'b0;
    chk1("drain_req_kept", mem_req, 1'b1);
    chk1("drain_busy", busy, 1'b1);
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    cyc();
    mem_ack = 1'b0;
    chk1("drain_done_busy", busy, 1'b0);
    chk1("drain_no_ack", if_ack, 1'b0);
    chk("drain_rdata_kept", if_rdata, exp_if);
    cyc();

    // flush together with ack in FETCH discards the data
    if_req = 1'b1; if_addr = 32'h510;
    cyc();
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h88888888;
    cyc();
    flush = 1'b0; mem_ack = 1'b0; if_req = 1'b0;
    chk1("flushack_busy", busy, 1'b0);
    chk1("flushack_no_ack", if_ack, 1'b0);
    chk("flushack_rdata", if_rdata, exp_if);
    cyc();

    // timeout on a fetch with mem_ack never asserted
    if_req = 1'b1; if_addr = 32'h600;
    exp_if = 32'h0;
    sbq.push_back('{is_ls: 1'b0, rdata: 32'h0});
    cyc();
    chk1("to_grant", mem_req, 1'b1);
    repeat (TO - 1) cyc();
    chk1("to_not_yet", mem_err, 1'b0);
    chk1("to_req_held", mem_req, 1'b1);
    cyc();
    chk1("to_err", mem_err, 1'b1);
    chk1("to_ack", if_ack, 1'b1);
    chk1("to_req_drop", mem_req, 1'b0);
    if_req = 1'b0;
    cyc();
    chk1("to_err_pulse", mem_err, 1'b0);
    chk1("to_req_low", mem_req, 1'b0);

    // reset during DATA abandons the transaction
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h700;
    cyc();
    chk1("rstmid_grant", mem_req, 1'b1);
    reset = 1'b1;
    cyc();
    chk1("rstmid_req", mem_req, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_no_ack", ls_ack, 1'b0);
    reset = 1'b0; ls_req = 1'b0;
    exp_if = '0; exp_ls = '0;
    cyc();
    xact(1'b1, 1'b0, 32'h704, 32'h0, 32'h13572468, 2);

    repeat (2) cyc();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
